// File: rtl/uart_rx.sv
// UART receive stage: synchronizes uart_rxd, samples mid-bit and reassembles
// 8/9-bit frames with 1/2 stop bits, writing good frames into the RX FIFO.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_n,
  input  logic [23:0] ckdiv,
  input  logic        data9b,
  input  logic        stop2b,
  output logic        rxbusy,
  output logic        rf_write,
  output logic [8:0]  rf_wbyte,
  input  logic        rf_full,
  output logic        ferr,
  output logic        oerr,
  input  logic        uart_rxd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s, rxd_d;
  logic [23:0]            timer, timer_n;
  logic [3:0]             idx, idx_n;
  logic                   stop_cnt, stop_cnt_n;
  logic                   ferr_flag, ferr_flag_n;
  logic [8:0]             rbyte, rbyte_n;
  logic                   write_n, ferr_n, oerr_n;
  logic [8:0]             wbyte_n;
  logic                   tick, stop_bad;
  logic [3:0]             last_idx;

  assign rxd_s    = sync[SYNC_STAGES-1];
  assign rxbusy   = (state != IDLE);
  assign tick     = (state != IDLE) && (timer == '0);
  assign last_idx = data9b ? 4'd8 : 4'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync      <= '1;
      rxd_d     <= 1'b1;
      timer     <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      ferr_flag <= 1'b0;
      rbyte     <= '0;
      rf_write  <= 1'b0;
      ferr      <= 1'b0;
      oerr      <= 1'b0;
      rf_wbyte  <= '0;
    end else if (!clr_n) begin
      state     <= IDLE;
      sync      <= '1;
      rxd_d     <= 1'b1;
      timer     <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      ferr_flag <= 1'b0;
      rbyte     <= '0;
      rf_write  <= 1'b0;
      ferr      <= 1'b0;
      oerr      <= 1'b0;
      rf_wbyte  <= '0;
    end else begin
      state     <= state_n;
      sync      <= {sync[SYNC_STAGES-2:0], uart_rxd};
      rxd_d     <= rxd_s;
      timer     <= timer_n;
      idx       <= idx_n;
      stop_cnt  <= stop_cnt_n;
      ferr_flag <= ferr_flag_n;
      rbyte     <= rbyte_n;
      rf_write  <= write_n;
      ferr      <= ferr_n;
      oerr      <= oerr_n;
      rf_wbyte  <= wbyte_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    idx_n       = idx;
    stop_cnt_n  = stop_cnt;
    ferr_flag_n = ferr_flag;
    rbyte_n     = rbyte;
    write_n     = 1'b0;
    ferr_n      = 1'b0;
    oerr_n      = 1'b0;
    wbyte_n     = rf_wbyte;
    stop_bad    = ferr_flag | ~rxd_s;

    if (state != IDLE)
      timer_n = tick ? ckdiv : timer - 1'b1;

    case (state)
      IDLE: begin
        if (rxd_d && !rxd_s) begin
          timer_n = {1'b0, ckdiv[23:1]};
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rxd_s) begin
            rbyte_n = '0;
            idx_n   = '0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          rbyte_n[idx] = rxd_s;
          idx_n        = idx + 1'b1;
          // >= rather than == so a mid-frame data9b change cannot run idx past the register
          if (idx >= last_idx) begin
            state_n     = STOP;
            stop_cnt_n  = stop2b;
            ferr_flag_n = 1'b0;
          end
        end
      end
      STOP: begin
        if (tick) begin
          ferr_flag_n = stop_bad;
          if (stop_cnt) begin
            stop_cnt_n = 1'b0;
          end else begin
            state_n = IDLE;
            if (stop_bad) begin
              ferr_n = 1'b1;
            end else if (rf_full) begin
              oerr_n = 1'b1;
            end else begin
              write_n = 1'b1;
              wbyte_n = rbyte;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage, the counterpart of the transmitter on the far end of the serial line.
- Samples the asynchronous uart_rxd line and reassembles 8- or 9-bit frames (1 or 2 stop bits).
- Writes each good frame into the RX FIFO through a write/full handshake.
- Shares ckdiv/clr_n/data9b/stop2b control semantics with the TX stage, so one register block drives both.

Parameters:
SYNC_STAGES, 2, number of flops in the uart_rxd synchronizer (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
clr_n  input  1  synchronous soft clear, active-low
ckdiv  input  24  bit period minus one, in clk cycles; bit period = ckdiv+1; legal range ckdiv >= 7
data9b  input  1  1 = 9 data bits, 0 = 8 data bits
stop2b  input  1  1 = 2 stop bits, 0 = 1 stop bit
rxbusy  output  1  high while a frame is in progress (state != IDLE)
rf_write  output  1  one-cycle write strobe to the RX FIFO
rf_wbyte  output  9  received data, LSB = first bit on the wire; bit 8 = 0 in 8-bit mode
rf_full  input  1  RX FIFO full
ferr  output  1  one-cycle pulse: framing error (a stop bit sampled low)
oerr  output  1  one-cycle pulse: overrun (good frame completed while rf_full=1)
uart_rxd  input  1  serial input, idle high, asynchronous to clk

Behaviour:
- Reset (rst_n=0, async) or clr_n=0 (sync):
  - state=IDLE; synchronizer flops and edge-detect flop = 1.
  - rf_write=0, ferr=0, oerr=0, rf_wbyte=0, bit counters=0.
  - A clear mid-frame abandons the frame with no write and no error pulse.
- Synchronizer: rxd_s is uart_rxd after SYNC_STAGES flops. rxd_d is rxd_s delayed by one cycle.
- Start detect: in IDLE, a cycle with rxd_d=1 and rxd_s=0 is a falling edge.
  - Load the bit timer with ckdiv>>1 and go to START.
  - A line held low never re-triggers; a high-to-low transition is required.
- Bit timer: decrements each cycle while not IDLE.
  - When it reaches 0, that cycle is a sample event and the timer reloads with ckdiv.
  - First sample event: (ckdiv>>1)+1 cycles after edge detect. Subsequent sample events: every ckdiv+1 cycles.
- States:
  - IDLE: wait for a falling edge.
  - START: at the sample event:
    - rxd_s=0: clear the data register, set bit index to 0, go to DATA.
    - rxd_s=1: glitch; return to IDLE with no write and no error.
  - DATA: at each sample event, rxd_s is stored at rbyte[index] and index increments.
    - After index reaches 7 (data9b=0) or 8 (data9b=1): go to STOP with stop count = stop2b and ferr_flag cleared.
  - STOP: at each sample event:
    - rxd_s=0 sets ferr_flag.
    - stop count != 0: decrement it and stay.
    - stop count == 0: resolve the frame (below) and go to IDLE.
- Frame resolution, in priority order; all outputs registered and asserted in the cycle after the final stop sample:
  - ferr_flag set: ferr=1, no write.
  - else rf_full=1: oerr=1, no write, byte dropped.
  - else: rf_write=1, rf_wbyte=rbyte.
- Outputs and configuration:
  - At most one of rf_write/ferr/oerr is high per frame.
  - rf_wbyte holds its value until the next write.
  - Return to IDLE happens mid-way through the last stop bit, so back-to-back frames are received with no gap.
  - data9b, stop2b and ckdiv must be stable while rxbusy=1; changes mid-frame give undefined data but must not hang the FSM.
- rxbusy is combinational from state: (state != IDLE).

Test Plan:
1. ckdiv=15, data9b=0, stop2b=0; send 8N1 frame 0xA5, rf_full=0 -> exactly one rf_write, rf_wbyte=9'h0A5, ferr=oerr=0, rxbusy low after the stop sample.
2. ckdiv=15, data9b=1, stop2b=1; send 9-bit 0x1C3 with 2 stop bits, then immediately 0x03C -> two rf_write pulses with 9'h1C3 then 9'h03C, no errors.
3. Glitch: uart_rxd low for 4 clk, then high (ckdiv=15) -> START samples high, back to IDLE, no rf_write/ferr/oerr.
4. Framing: 8N1 frame 0x55 with the stop bit driven low, then line high -> one ferr pulse, no rf_write. Next valid frame 0x12 -> rf_wbyte=9'h012.
5. Overrun: rf_full=1 during a good 0x7E frame -> one oerr pulse, no rf_write, rf_wbyte unchanged. With rf_full=0 the next frame is written.
6. clr_n pulsed low for 1 clk mid-DATA of frame 0xFF -> rxbusy=0 next cycle, no write/error. A subsequent frame 0x81 is received correctly. Repeat with rst_n asserted asynchronously; all outputs go 0 immediately.
